// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory geometry, word width and the
// program-loader state encoding.
package cpu_pkg;

  localparam int unsigned IMEM_DEPTH = 16;
  localparam int unsigned IMEM_AW    = 4;
  localparam int unsigned WORD_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/prog_loader_csum.sv
// Running XOR over the data bytes of a load session; cleared when a session
// starts and updated on every accepted data byte.
module prog_loader_csum
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              update,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] csum
);

  logic [WORD_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear) begin
      csum_d = '0;
    end else if (update) begin
      csum_d = csum_q ^ data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a length-prefixed program into instruction memory
// while holding the CPU. Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [WORD_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  loader_state_e     state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [4:0]        len_q, len_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;

`ifdef PROG_LOADER_CSUM_EN
  logic              csum_clear;
  logic              csum_update;
  logic [WORD_W-1:0] csum;

  prog_loader_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .clear  (csum_clear),
    .update (csum_update),
    .data   (byte_data),
    .csum   (csum)
  );
`endif

  assign accept = byte_valid & byte_ready_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CSUM_EN
    csum_clear  = 1'b0;
    csum_update = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
`ifdef PROG_LOADER_CSUM_EN
          csum_clear = 1'b1;
`endif
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (byte_data != '0 && byte_data <= WORD_W'(IMEM_DEPTH)) begin
            state_d = ST_LOAD;
            count_d = '0;
            len_d   = byte_data[4:0];
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {{(WORD_W-IMEM_AW){1'b0}}, count_q[IMEM_AW-1:0]};
          mem_wdata_d = byte_data;
          count_d     = count_q + 5'd1;
`ifdef PROG_LOADER_CSUM_EN
          csum_update = 1'b1;
          if (count_d == len_q) state_d = ST_CSUM;
`else
          if (count_d == len_q) state_d = ST_DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d = (byte_data == csum) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    byte_ready_d = state_d inside {ST_LEN, ST_LOAD, ST_CSUM};
    cpu_hold_d   = state_d inside {ST_LEN, ST_LOAD, ST_CSUM, ST_ERR};
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      len_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: sessions are modelled as a list of
// expected (address, data) writes plus a final done/error outcome.
module tb_prog_loader;

`ifdef PROG_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       error;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned writes_seen = 0;
  logic        done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, and
  // done may only rise once all expected writes have been observed.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      writes_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      chk("done_with_pending_writes", sb.size(), 0);
    end
    done_prev = done;
  end

  task automatic wait_ready();
    int n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got byte_ready %0b expected 1 within 50 cycles", byte_ready);
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b, input int unsigned gap);
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    wait_ready();
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("session_ready", byte_ready, 1'b1);
    chk("session_hold", cpu_hold, 1'b1);
    chk("session_flags", {done, error}, 2'b00);
  endtask

  task automatic run_session(input logic [7:0] len, input logic [7:0] d[$],
                             input logic [7:0] csum, input int unsigned max_gap,
                             input int pulse_at);
    logic [7:0] x;
    bit         len_ok;
    bit         exp_done;
    len_ok = (len >= 8'd1) && (len <= 8'd16);
    x = 8'h00;
    foreach (d[i]) x ^= d[i];
    start_session();
    send(len, $urandom_range(max_gap, 0));
    if (!len_ok) begin
      byte_valid = 1'b0;
      chk("badlen_error", error, 1'b1);
      chk("badlen_hold", cpu_hold, 1'b1);
      chk("badlen_ready_done_we", {byte_ready, done, mem_we}, 3'b000);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      wr_t w;
      if (i == pulse_at) begin
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_load_ready_hold", {byte_ready, cpu_hold}, 2'b11);
        chk("start_in_load_flags", {done, error, mem_we}, 3'b000);
      end
      w.addr = 8'(i);
      w.data = d[i];
      sb.push_back(w);
      send(d[i], $urandom_range(max_gap, 0));
    end
    chk("final_write_state", {mem_we, done, byte_ready}, CSUM_EN ? 3'b101 : 3'b110);
    if (CSUM_EN) send(csum, $urandom_range(max_gap, 0));
    byte_valid = 1'b0;
    exp_done = !CSUM_EN || (csum == x);
    chk("end_done", done, exp_done);
    chk("end_error", error, !exp_done);
    chk("end_hold", cpu_hold, !exp_done);
    chk("end_ready", byte_ready, 1'b0);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  len;
    logic [7:0]  x;
    int unsigned snap;

    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {byte_ready, cpu_hold, done, error}, 4'b0000);

    q = {8'h1A, 8'h2B, 8'hF0};
    run_session(8'h03, q, 8'hC1, 0, -1);

    q = {};
    run_session(8'h00, q, 8'h00, 0, -1);
    run_session(8'h11, q, 8'h00, 0, -1);

    q = {8'h55, 8'hAA};
    run_session(8'h02, q, 8'h00, 0, -1);
    run_session(8'h02, q, 8'hFF, 1, -1);

    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    x = 8'h00;
    foreach (q[i]) x ^= q[i];
    run_session(8'h10, q, x, 3, -1);

    q = {8'h11, 8'h22, 8'h33, 8'h44};
    run_session(8'h04, q, 8'h44, 0, 2);

    // Reset after two of four data bytes, with start/byte_valid also high.
    start_session();
    snap = writes_seen;
    send(8'h04, 0);
    sb.push_back('{addr: 8'h00, data: 8'hC3});
    sb.push_back('{addr: 8'h01, data: 8'h3C});
    send(8'hC3, 0);
    send(8'h3C, 0);
    rst = 1'b1;
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h77;
    @(posedge clk);
    #1;
    chk("midreset_outputs", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}, 0);
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_idle", {byte_ready, cpu_hold, mem_we}, 3'b000);
    chk("midreset_write_count", writes_seen - snap, 2);

    for (int s = 0; s < 8; s++) begin
      len = 8'($urandom_range(18, 0));
      q = {};
      if (len >= 8'd1 && len <= 8'd16) begin
        for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
      end
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
      run_session(len, q, x, 2, -1);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  begin a load session; sampled in IDLE, DONE, ERR.
REQ-004 byte_valid  input  1  host byte stream valid.
REQ-005 byte_data  input  8  host byte stream data.
REQ-006 byte_ready  output  1  loader can accept a byte; transfer when byte_valid & byte_ready at a rising edge.
REQ-007 mem_we  output  1  instruction-memory write strobe, one cycle per stored instruction.
REQ-008 mem_addr  output  8  instruction-memory write address; bits [7:4] always 0.
REQ-009 mem_wdata  output  8  instruction word to store.
REQ-010 cpu_hold  output  1  holds CPU (PC/controller) idle while memory is being written.
REQ-011 done  output  1  level; program loaded successfully.
REQ-012 error  output  1  level; session aborted.

Function
REQ-013 States: IDLE, LEN, LOAD, CSUM, DONE, ERR; state register and all outputs registered.
REQ-014 IDLE: byte_ready=0, cpu_hold=0; start=1 -> LEN next cycle, cpu_hold=1 from that cycle.
REQ-015 LEN: byte_ready=1; accepted byte is length N; N in 1..16 -> LOAD with count=0; N=0 or N>16 -> ERR.
REQ-016 LOAD: byte_ready=1; each accepted byte produces mem_we=1, mem_addr={4'h0,count}, mem_wdata=byte exactly one cycle after acceptance; count increments by 1.
REQ-017 LOAD: after the Nth byte is accepted -> CSUM (macro on) or DONE (macro off); no write ever issued to address >= N.
REQ-018 Back-to-back bytes (byte_valid held high) accepted one per cycle; zero bubbles; byte_ready never gated by mem_we.
REQ-019 byte_valid=0 in LEN/LOAD/CSUM: state, count held; no timeout.
REQ-020 DONE: done=1, cpu_hold=0, byte_ready=0; start=1 -> LEN, done cleared same edge.
REQ-021 ERR: error=1, cpu_hold=1, byte_ready=0; only start=1 or rst leaves ERR (-> LEN, error cleared).
REQ-022 start outside IDLE/DONE/ERR is ignored.
REQ-023 The final mem_we of a session is issued in the same cycle the state becomes CSUM or DONE; done never asserts before the last write is visible.
REQ-024 count is 5 bits; never wraps past 16 (guaranteed by REQ-015).

Reset
REQ-025 rst=1 at a rising edge: state=IDLE, count=0, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0.
REQ-026 rst mid-session aborts without a final write; memory locations already written keep their contents.
REQ-027 rst dominates start and byte_valid in the same cycle.

Configuration
REQ-028 Macro PROG_LOADER_CSUM_EN defined: after N data bytes, one checksum byte is accepted in CSUM; equal to XOR of all N data bytes -> DONE, else -> ERR (memory already written, done stays 0).
REQ-029 Macro undefined: CSUM state, XOR register and checksum byte absent; LOAD -> DONE directly.

Structure
REQ-030 Shared package cpu_pkg holds IMEM_DEPTH=16, IMEM_AW=4, WORD_W=8, and the loader state enum.
REQ-031 One sub-module, prog_loader_csum (8-bit running XOR; clear on entering LEN, update on accepted LOAD byte), instantiated only under PROG_LOADER_CSUM_EN.

Verification
REQ-032 start; bytes 03,1A,2B,F0 (+csum C1 if macro) back-to-back -> writes (0,1A),(1,2B),(2,F0) on consecutive cycles, then done=1, cpu_hold=0.
REQ-033 Length 00, and separately length 11h -> ERR, error=1, no mem_we, cpu_hold=1; start -> LEN, error=0.
REQ-034 Macro on: 02,55,AA, csum 00 -> both writes issued, ERR; csum FF -> DONE.
REQ-035 Length 10h, 16 bytes with random byte_valid gaps -> 16 writes at addresses 00..0F in order, no write to 10h.
REQ-036 rst asserted after 2 of 4 data bytes -> IDLE next cycle, all outputs at reset values, exactly 2 writes observed.
REQ-037 start pulsed while in LOAD -> ignored, count and state unchanged.
